// File: rtl/lab3_mem_responder_pkg.sv
// ---------------------------------------------------------------------------
// lab3_mem_responder_pkg
//
// Shared definitions for the lab3 memory responder:
//   - mem_req_4B_t / mem_resp_4B_t message layouts of the 4-byte val/rdy
//     memory protocol (field order is MSB first, matching the cache side)
//   - type_ encodings for READ / WRITE / INIT
//   - small helpers used by the responder datapath
//
// Request  (77 bits): {type_[2:0], opaque[7:0], addr[31:0], len[1:0], data[31:0]}
// Response (47 bits): {type_[2:0], opaque[7:0], test[1:0], len[1:0], data[31:0]}
// ---------------------------------------------------------------------------
package lab3_mem_responder_pkg;

  // Message type_ codes shared with the cache.
  localparam logic [2:0] MEM_TYPE_READ  = 3'd0;
  localparam logic [2:0] MEM_TYPE_WRITE = 3'd1;
  localparam logic [2:0] MEM_TYPE_INIT  = 3'd2;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

  localparam int MEM_REQ_W  = $bits(mem_req_4B_t);
  localparam int MEM_RESP_W = $bits(mem_resp_4B_t);

  // Width of the latency down-counter. A zero-latency build still keeps
  // a one-bit counter so the datapath never has a zero-width vector.
  function automatic int lat_cnt_width(input int lat);
    int w;
    w = (lat < 1) ? 1 : $clog2(lat + 1);
    if (w < 1) w = 1;
    return w;
  endfunction

  // INIT behaves exactly like WRITE as far as the word array is concerned.
  function automatic logic is_array_write(input logic [2:0] type_);
    return (type_ == MEM_TYPE_WRITE) || (type_ == MEM_TYPE_INIT);
  endfunction

  // Assemble the response for an accepted request. Only READ carries
  // array data back; every other type_ (including unknown codes) returns
  // zero data with type_, opaque and len echoed and test cleared.
  function automatic mem_resp_4B_t make_resp(
    input logic [2:0]  type_,
    input logic [7:0]  opaque,
    input logic [1:0]  len,
    input logic [31:0] rd_data
  );
    mem_resp_4B_t r;
    r        = '0;
    r.type_  = type_;
    r.opaque = opaque;
    r.test   = 2'b00;
    r.len    = len;
    r.data   = (type_ == MEM_TYPE_READ) ? rd_data : 32'h0;
    return r;
  endfunction

endpackage

// File: rtl/lab3_mem_responder_word_array.sv
// ---------------------------------------------------------------------------
// lab3_mem_word_array
//
// Single-port NUM_WORDS x 32 word store backing the memory responder.
// Reads are combinational from the same index used for writing, writes
// land on the rising clock edge. Contents are deliberately not reset so
// the array maps onto plain RAM.
//
// Ports:
//   clk      in   clock, rising edge
//   wr_en    in   write strobe, sampled on the rising edge
//   idx      in   word index ($clog2(NUM_WORDS) bits)
//   wr_data  in   32-bit write data
//   rd_data  out  32-bit combinational read data at idx
// ---------------------------------------------------------------------------
module lab3_mem_word_array #(
  parameter int NUM_WORDS = 256
) (
  input  logic                         clk,
  input  logic                         wr_en,
  input  logic [$clog2(NUM_WORDS)-1:0] idx,
  input  logic [31:0]                  wr_data,
  output logic [31:0]                  rd_data
);

  logic [31:0] mem [NUM_WORDS];

  // Synchronous write; no reset so the storage stays RAM-friendly.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[idx] <= wr_data;
    end
  end

  // Combinational read sees a word written on the previous edge, which is
  // what gives read-after-write behaviour one cycle later.
  assign rd_data = mem[idx];

endmodule

// File: rtl/lab3_mem_responder.sv
// ---------------------------------------------------------------------------
// lab3_mem_responder
//
// Memory-side responder for the 4-byte val/rdy memory protocol. Accepts
// one request at a time from the cache refill/write port, services it
// against an internal word array and presents the response LATENCY extra
// cycles later. With LATENCY=0 and memresp_rdy held high it sustains one
// request per cycle by accepting the next request on the same edge that
// retires the current response.
//
// Parameters:
//   NUM_WORDS  depth of the word array (power of two)
//   LATENCY    extra cycles between accept and memresp_val, 0..15
//
// Ports:
//   clk          in   clock, rising edge
//   reset        in   asynchronous, active-low reset
//   memreq_val   in   request valid
//   memreq_rdy   out  request ready (combinational on state/memresp_rdy)
//   memreq_msg   in   mem_req_4B_t  {type_, opaque, addr, len, data}
//   memresp_val  out  response valid (registered)
//   memresp_rdy  in   response ready from the cache
//   memresp_msg  out  mem_resp_4B_t {type_, opaque, test, len, data}
//   num_reads    out  saturating count of accepted READs   (stats build)
//   num_writes   out  saturating count of accepted WRITEs  (stats build)
//
// Optional feature: define LAB3_MEM_RESPONDER_STATS_EN to add the
// num_reads/num_writes ports and counters. Without it the block behaves
// identically, only the statistics are absent.
// ---------------------------------------------------------------------------
module lab3_mem_responder
  import lab3_mem_responder_pkg::*;
#(
  parameter int NUM_WORDS = 256,
  parameter int LATENCY   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  memreq_val,
  output logic                  memreq_rdy,
  input  logic [MEM_REQ_W-1:0]  memreq_msg,
  output logic                  memresp_val,
  input  logic                  memresp_rdy,
  output logic [MEM_RESP_W-1:0] memresp_msg
`ifdef LAB3_MEM_RESPONDER_STATS_EN
  ,
  output logic [31:0]           num_reads,
  output logic [31:0]           num_writes
`endif
);

  localparam int IDX_W = $clog2(NUM_WORDS);
  localparam int CNT_W = lat_cnt_width(LATENCY);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t       state;
  logic [CNT_W-1:0] lat_cnt;
  mem_resp_4B_t resp_q;
  logic         resp_val_q;

  mem_req_4B_t  req;
  mem_resp_4B_t resp_next;
  logic [IDX_W-1:0] word_idx;
  logic [31:0]  rd_data;
  logic         accept;
  logic         arr_wr_en;

  // Address bits outside the word index are intentionally ignored: the
  // byte offset and everything above the array depth alias onto it.
  logic         unused_addr_bits;

  assign req      = mem_req_4B_t'(memreq_msg);
  assign word_idx = req.addr[IDX_W+1:2];
  assign unused_addr_bits = ^{req.addr[31:IDX_W+2], req.addr[1:0]};

  // A new request may enter when idle, or on the very edge the pending
  // response is consumed. memreq_val never feeds back into this.
  assign memreq_rdy = (state == ST_IDLE) || ((state == ST_RESP) && memresp_rdy);
  assign accept     = memreq_val && memreq_rdy;
  assign arr_wr_en  = accept && is_array_write(req.type_);

  lab3_mem_word_array #(
    .NUM_WORDS (NUM_WORDS)
  ) u_word_array (
    .clk     (clk),
    .wr_en   (arr_wr_en),
    .idx     (word_idx),
    .wr_data (req.data),
    .rd_data (rd_data)
  );

  // Response contents are fully determined at accept time; read data is
  // the array word before any write on this same edge (only a READ uses it).
  always_comb begin
    resp_next = '0;
    resp_next = make_resp(req.type_, req.opaque, req.len, rd_data);
  end

  // Request/response FSM. An accept always (re)loads the response register
  // and the latency counter regardless of whether it comes from IDLE or
  // from a RESP handshake, so the two cases share one path.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      resp_q     <= '0;
      resp_val_q <= 1'b0;
    end else if (accept) begin
      resp_q <= resp_next;
      if (LATENCY > 0) begin
        state      <= ST_WAIT;
        lat_cnt    <= CNT_W'(LATENCY - 1);
        resp_val_q <= 1'b0;
      end else begin
        state      <= ST_RESP;
        lat_cnt    <= '0;
        resp_val_q <= 1'b1;
      end
    end else begin
      case (state)
        ST_IDLE: begin
          resp_val_q <= 1'b0;
        end
        ST_WAIT: begin
          if (lat_cnt == '0) begin
            state      <= ST_RESP;
            resp_val_q <= 1'b1;
          end else begin
            lat_cnt <= lat_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (memresp_rdy) begin
            state      <= ST_IDLE;
            resp_val_q <= 1'b0;
          end
        end
        default: begin
          state      <= ST_IDLE;
          resp_val_q <= 1'b0;
        end
      endcase
    end
  end

  assign memresp_val = resp_val_q;
  assign memresp_msg = resp_q;

`ifdef LAB3_MEM_RESPONDER_STATS_EN
  logic [31:0] reads_q;
  logic [31:0] writes_q;

  // Saturating traffic counters. INIT is a test-harness preload and is
  // kept out of the write count on purpose.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      reads_q  <= '0;
      writes_q <= '0;
    end else if (accept) begin
      if ((req.type_ == MEM_TYPE_READ) && (reads_q != 32'hFFFF_FFFF)) begin
        reads_q <= reads_q + 32'd1;
      end
      if ((req.type_ == MEM_TYPE_WRITE) && (writes_q != 32'hFFFF_FFFF)) begin
        writes_q <= writes_q + 32'd1;
      end
    end
  end

  assign num_reads  = reads_q;
  assign num_writes = writes_q;
`endif

endmodule

// File: tb/tb_lab3_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_lab3_mem_responder
//
// Drives two responders: one with LATENCY=3 for single-transaction timing,
// backpressure, aliasing and reset behaviour, and one with LATENCY=0 for a
// back-to-back stream. Expected responses come from a word-array model that
// applies the protocol rules directly (index = (addr/4) mod depth).
// ---------------------------------------------------------------------------
module tb_lab3_mem_responder;
  import lab3_mem_responder_pkg::*;

  localparam int NW  = 256;
  localparam int LAT = 3;

  logic        clk;
  logic        reset;

  logic        memreq_val, memreq_rdy, memresp_val, memresp_rdy;
  logic [76:0] memreq_msg;
  logic [46:0] memresp_msg;

  logic        memreq_val0, memreq_rdy0, memresp_val0, memresp_rdy0;
  logic [76:0] memreq_msg0;
  logic [46:0] memresp_msg0;

`ifdef LAB3_MEM_RESPONDER_STATS_EN
  logic [31:0] num_reads, num_writes, num_reads0, num_writes0;
`endif

  int checks = 0;
  int errors = 0;

  logic [31:0] model_mem [2][NW];
  int          exp_reads  [2];
  int          exp_writes [2];

  lab3_mem_responder #(.NUM_WORDS(NW), .LATENCY(LAT)) dut (
    .clk         (clk),
    .reset       (reset),
    .memreq_val  (memreq_val),
    .memreq_rdy  (memreq_rdy),
    .memreq_msg  (memreq_msg),
    .memresp_val (memresp_val),
    .memresp_rdy (memresp_rdy),
    .memresp_msg (memresp_msg)
`ifdef LAB3_MEM_RESPONDER_STATS_EN
    ,
    .num_reads   (num_reads),
    .num_writes  (num_writes)
`endif
  );

  lab3_mem_responder #(.NUM_WORDS(NW), .LATENCY(0)) dut0 (
    .clk         (clk),
    .reset       (reset),
    .memreq_val  (memreq_val0),
    .memreq_rdy  (memreq_rdy0),
    .memreq_msg  (memreq_msg0),
    .memresp_val (memresp_val0),
    .memresp_rdy (memresp_rdy0),
    .memresp_msg (memresp_msg0)
`ifdef LAB3_MEM_RESPONDER_STATS_EN
    ,
    .num_reads   (num_reads0),
    .num_writes  (num_writes0)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference behaviour: compute the response and update the model array.
  task automatic modelTxn(input int inst, input logic [2:0] t, input logic [7:0] op,
                          input logic [31:0] addr, input logic [1:0] len,
                          input logic [31:0] data, output logic [46:0] resp);
    int idx;
    logic [31:0] d;
    idx = int'((addr / 32'd4) % 32'(NW));
    d = 32'h0;
    if (t == MEM_TYPE_READ) begin
      d = model_mem[inst][idx];
      exp_reads[inst]++;
    end else if (t == MEM_TYPE_WRITE) begin
      model_mem[inst][idx] = data;
      exp_writes[inst]++;
    end else if (t == MEM_TYPE_INIT) begin
      model_mem[inst][idx] = data;
    end
    resp = {t, op, 2'b00, len, d};
  endtask

  task automatic checkStats(input string tag);
`ifdef LAB3_MEM_RESPONDER_STATS_EN
    checkOutput({tag, "_reads"},   64'(num_reads),   64'(exp_reads[0]));
    checkOutput({tag, "_writes"},  64'(num_writes),  64'(exp_writes[0]));
    checkOutput({tag, "_reads0"},  64'(num_reads0),  64'(exp_reads[1]));
    checkOutput({tag, "_writes0"}, 64'(num_writes0), 64'(exp_writes[1]));
`else
    checkOutput({tag, "_noresp_idle"}, 64'(memresp_val0), 64'(0));
`endif
  endtask

  // Called at a negedge with dut idle; returns at the negedge after accept.
  task automatic applyStimulus(input logic [2:0] t, input logic [7:0] op,
                               input logic [31:0] addr, input logic [1:0] len,
                               input logic [31:0] data);
    memreq_val = 1'b1;
    memreq_msg = {t, op, addr, len, data};
    checkOutput("req_rdy_idle", 64'(memreq_rdy), 64'(1));
    @(posedge clk);
    @(negedge clk);
    memreq_val = 1'b0;
    memreq_msg = {13'($urandom), $urandom, $urandom};
  endtask

  task automatic waitResp(output int n);
    n = 0;
    while (memresp_val !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic doTxn(input logic [2:0] t, input logic [7:0] op, input logic [31:0] addr,
                       input logic [1:0] len, input logic [31:0] data, input int hold,
                       output logic [46:0] obs);
    logic [46:0] expv;
    int n;
    modelTxn(0, t, op, addr, len, data, expv);
    applyStimulus(t, op, addr, len, data);
    waitResp(n);
    checkOutput("latency", 64'(n), 64'(LAT));
    checkOutput("resp_msg", 64'(memresp_msg), 64'(expv));
    obs = memresp_msg;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      checkOutput("hold_val", 64'(memresp_val), 64'(1));
      checkOutput("hold_msg", 64'(memresp_msg), 64'(expv));
      checkOutput("hold_req_rdy", 64'(memreq_rdy), 64'(0));
    end
    memresp_rdy = 1'b1;
    @(negedge clk);
    memresp_rdy = 1'b0;
    checkOutput("post_val", 64'(memresp_val), 64'(0));
    checkOutput("post_req_rdy", 64'(memreq_rdy), 64'(1));
  endtask

  logic [46:0] obs;
  logic [46:0] expv;
  logic [76:0] reqs [34];
  logic [46:0] exp0 [34];
  int          n;

  initial begin
    memreq_val   = 1'b0;
    memreq_msg   = '0;
    memresp_rdy  = 1'b0;
    memreq_val0  = 1'b0;
    memreq_msg0  = '0;
    memresp_rdy0 = 1'b1;
    reset        = 1'b0;

    repeat (2) @(negedge clk);
    checkOutput("rst_val", 64'(memresp_val), 64'(0));
    checkOutput("rst_msg", 64'(memresp_msg), 64'(0));
    checkOutput("rst_req_rdy", 64'(memreq_rdy), 64'(1));
    checkOutput("rst_val0", 64'(memresp_val0), 64'(0));
    reset = 1'b1;
    @(negedge clk);
    checkOutput("idle_val", 64'(memresp_val), 64'(0));
    checkStats("rst_stats");

    $display("[TB] write/read 0x40");
    doTxn(MEM_TYPE_WRITE, 8'h11, 32'h0000_0040, 2'd0, 32'hDEAD_BEEF, 0, obs);
    doTxn(MEM_TYPE_READ, 8'h22, 32'h0000_0040, 2'd0, 32'h0, 0, obs);
    checkOutput("rd40_data", 64'(obs[31:0]), 64'(32'hDEAD_BEEF));
    checkOutput("rd40_opaque", 64'(obs[43:36]), 64'(8'h22));
    checkOutput("rd40_test", 64'(obs[35:34]), 64'(0));

    $display("[TB] backpressure 5 cycles");
    doTxn(MEM_TYPE_READ, 8'h44, 32'h0000_0042, 2'd1, 32'h0, 5, obs);

    $display("[TB] aliasing 0x400 -> 0x0");
    doTxn(MEM_TYPE_WRITE, 8'h55, 32'h0000_0400, 2'd2, 32'hCAFE_F00D, 0, obs);
    doTxn(MEM_TYPE_READ, 8'h66, 32'h0000_0000, 2'd3, 32'h0, 1, obs);
    checkOutput("alias_data", 64'(obs[31:0]), 64'(32'hCAFE_F00D));

    for (int i = 0; i < 16; i++) begin
      doTxn(MEM_TYPE_INIT, 8'(i), 32'(i * 4), 2'd0, $urandom, 0, obs);
    end

    doTxn(3'd5, 8'h77, 32'h0000_0008, 2'd1, 32'h1234_5678, 0, obs);
    checkOutput("unk_type", 64'(obs[46:44]), 64'(5));
    checkOutput("unk_data", 64'(obs[31:0]), 64'(0));
    checkStats("directed_stats");

    $display("[TB] random transactions");
    for (int k = 0; k < 40; k++) begin
      int r;
      logic [2:0] t;
      logic [31:0] addr;
      r = int'($urandom_range(0, 9));
      if (r < 4)      t = MEM_TYPE_READ;
      else if (r < 7) t = MEM_TYPE_WRITE;
      else if (r < 8) t = MEM_TYPE_INIT;
      else            t = 3'($urandom_range(3, 7));
      addr = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2) | ($urandom & 32'h3);
      doTxn(t, 8'($urandom), addr, 2'($urandom), $urandom, int'($urandom_range(0, 3)), obs);
    end
    checkStats("random_stats");

    $display("[TB] reset during response");
    modelTxn(0, MEM_TYPE_READ, 8'h81, 32'h0000_000C, 2'd0, 32'h0, expv);
    applyStimulus(MEM_TYPE_READ, 8'h81, 32'h0000_000C, 2'd0, 32'h0);
    waitResp(n);
    checkOutput("rr_val_before", 64'(memresp_val), 64'(1));
    #2 reset = 1'b0;
    #1;
    checkOutput("rr_async_val", 64'(memresp_val), 64'(0));
    checkOutput("rr_async_msg", 64'(memresp_msg), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    exp_reads  = '{0, 0};
    exp_writes = '{0, 0};
    checkOutput("rr_req_rdy", 64'(memreq_rdy), 64'(1));
    checkStats("rr_stats");

    $display("[TB] reset during wait");
    modelTxn(0, MEM_TYPE_READ, 8'h82, 32'h0000_0010, 2'd1, 32'h0, expv);
    applyStimulus(MEM_TYPE_READ, 8'h82, 32'h0000_0010, 2'd1, 32'h0);
    #2 reset = 1'b0;
    #1;
    checkOutput("rw_async_val", 64'(memresp_val), 64'(0));
    checkOutput("rw_async_msg", 64'(memresp_msg), 64'(0));
    @(negedge clk);
    reset = 1'b1;
    exp_reads  = '{0, 0};
    exp_writes = '{0, 0};
    for (int i = 0; i < LAT + 2; i++) begin
      @(negedge clk);
      checkOutput("rw_dropped", 64'(memresp_val), 64'(0));
    end
    checkStats("rw_stats");
    doTxn(MEM_TYPE_READ, 8'h83, 32'h0000_0040, 2'd2, 32'h0, 0, obs);
    checkOutput("after_rst_data", 64'(obs[31:0]), 64'(32'hDEAD_BEEF));
    checkStats("after_rst_stats");

    $display("[TB] back-to-back stream, latency 0");
    for (int i = 0; i < 34; i++) begin
      logic [2:0] t;
      logic [31:0] addr, data;
      logic [1:0] len;
      if (i < 16)      begin t = MEM_TYPE_WRITE; addr = 32'(i * 4); end
      else if (i < 32) begin t = MEM_TYPE_READ;  addr = 32'((i - 16) * 4); end
      else if (i == 32) begin t = MEM_TYPE_WRITE; addr = 32'(20 * 4); end
      else             begin t = MEM_TYPE_READ;  addr = 32'(20 * 4) | 32'h2; end
      data = (t == MEM_TYPE_WRITE) ? $urandom : 32'h0;
      len  = 2'($urandom);
      reqs[i] = {t, 8'(i), addr, len, data};
      modelTxn(1, t, 8'(i), addr, len, data, exp0[i]);
    end
    for (int i = 0; i < 34; i++) begin
      memreq_val0 = 1'b1;
      memreq_msg0 = reqs[i];
      checkOutput("b2b_req_rdy", 64'(memreq_rdy0), 64'(1));
      if (i == 0) begin
        checkOutput("b2b_first_val", 64'(memresp_val0), 64'(0));
      end else begin
        checkOutput("b2b_val", 64'(memresp_val0), 64'(1));
        checkOutput("b2b_msg", 64'(memresp_msg0), 64'(exp0[i-1]));
      end
      @(negedge clk);
    end
    memreq_val0 = 1'b0;
    checkOutput("b2b_last_val", 64'(memresp_val0), 64'(1));
    checkOutput("b2b_last_msg", 64'(memresp_msg0), 64'(exp0[33]));
    @(negedge clk);
    checkOutput("b2b_drain_val", 64'(memresp_val0), 64'(0));
    checkStats("final_stats");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
